// File: rtl/ysyx_23060203_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: opcode constant, reset PC,
// FSM state type and the B-type immediate decoder.
package ysyx_23060203_ifu_pkg;

  localparam logic [4:0]  OP_BRANCH        = 5'b11000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold
  } ifu_state_e;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ysyx_23060203_ifu_pred.sv
// Static next-PC predictor: backward conditional branches are taken, everything
// else falls through to pc + 4.
module ysyx_23060203_ifu_pred
  import ysyx_23060203_ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [31:0] npc
);

  always_comb begin
    npc = pc + 32'd4;
    if (inst[6:2] == OP_BRANCH && inst[31]) begin
      npc = pc + imm_b(inst);
    end
  end

endmodule

// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: one outstanding AXI4-Lite-style read, one-entry
// instruction buffer. Define YSYX_23060203_IFU_RESP_CHECK_EN to add out_fetch_err.
module ysyx_23060203_ifu
  import ysyx_23060203_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_araddr,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        jump_flush,
  input  logic [31:0] jump_dnpc,
  input  logic        flush,
  input  logic [31:0] flush_dnpc
`ifdef YSYX_23060203_IFU_RESP_CHECK_EN
  ,
  output logic        out_fetch_err
`endif
);

  ifu_state_e  state_q;
  logic [31:0] pc_q, inst_buf_q, tgt_q, npc;
  logic        discard_q, arvalid_q, rready_q;
  logic        redir;
  logic [31:0] redir_pc;

  assign redir    = flush | jump_flush;
  assign redir_pc = flush ? flush_dnpc : jump_dnpc;

  ysyx_23060203_ifu_pred u_pred (
    .pc   (pc_q),
    .inst (inst_buf_q),
    .npc  (npc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      inst_buf_q <= '0;
      tgt_q      <= RESET_PC;
      discard_q  <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StReq: begin
          if (!arvalid_q) begin
            // Address not yet on the bus, so a redirect can retarget it directly.
            arvalid_q <= 1'b1;
            if (redir) pc_q <= redir_pc;
          end else if (mem_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StWait;
            if (redir) begin
              pc_q      <= redir_pc;
              discard_q <= 1'b1;
            end else if (discard_q) begin
              pc_q <= tgt_q;
            end
          end else if (redir) begin
            // Issued address must stay stable; remember the target for later.
            discard_q <= 1'b1;
            tgt_q     <= redir_pc;
          end
        end
        StWait: begin
          if (mem_rvalid) begin
            rready_q <= 1'b0;
            if (discard_q || redir) begin
              discard_q <= 1'b0;
              if (redir) pc_q <= redir_pc;
              arvalid_q <= 1'b1;
              state_q   <= StReq;
            end else begin
              inst_buf_q <= mem_rdata;
              state_q    <= StHold;
            end
          end else if (redir) begin
            pc_q      <= redir_pc;
            discard_q <= 1'b1;
          end
        end
        StHold: begin
          if (redir) begin
            pc_q      <= redir_pc;
            arvalid_q <= 1'b1;
            state_q   <= StReq;
          end else if (out_ready) begin
            pc_q      <= npc;
            arvalid_q <= 1'b1;
            state_q   <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

`ifdef YSYX_23060203_IFU_RESP_CHECK_EN
  logic fetch_err_q;

  always_ff @(posedge clock) begin
    if (reset || redir) begin
      fetch_err_q <= 1'b0;
    end else if (state_q == StWait && mem_rvalid && !discard_q) begin
      fetch_err_q <= |mem_rresp;
    end
  end

  assign out_fetch_err = fetch_err_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^mem_rresp;
`endif

  assign mem_araddr  = pc_q;
  assign mem_arvalid = arvalid_q;
  assign mem_rready  = rready_q;
  // Gated so a wrong-path instruction is never accepted in a redirect cycle.
  assign out_valid   = (state_q == StHold) && !redir;
  assign out_pc      = pc_q;
  assign out_inst    = inst_buf_q;

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Self-checking bench for ysyx_23060203_ifu: memory responder plus a
// program-order reference model of the fetched instruction stream.
module tb_ysyx_23060203_ifu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_araddr, mem_rdata, out_pc, out_inst;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready, out_valid;
  logic [1:0]  mem_rresp;
  logic        out_ready = 1'b0;
  logic        jump_flush = 1'b0, flush = 1'b0;
  logic [31:0] jump_dnpc = '0, flush_dnpc = '0;
`ifdef YSYX_23060203_IFU_RESP_CHECK_EN
  logic        out_fetch_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ysyx_23060203_ifu dut (
    .clock       (clock),
    .reset       (reset),
    .mem_araddr  (mem_araddr),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rvalid  (mem_rvalid),
    .mem_rready  (mem_rready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .jump_flush  (jump_flush),
    .jump_dnpc   (jump_dnpc),
    .flush       (flush),
    .flush_dnpc  (flush_dnpc)
`ifdef YSYX_23060203_IFU_RESP_CHECK_EN
    ,
    .out_fetch_err (out_fetch_err)
`endif
  );

  // ---------------- memory contents ----------------
  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (mem_ovr.exists(a)) return mem_ovr[a];
    h = (a ^ 32'h5bd1_e995) * 32'h9e37_79b1;
    h = h ^ (h >> 15);
    if (h[1:0] == 2'b00) return {h[31:7], 7'b1100011};
    return {h[31:7], 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm);
    logic [31:0] i;
    i = imm;
    return {i[12], i[10:5], 5'd0, 5'd0, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  // Architectural rule: backward conditional branch taken, otherwise sequential.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] inst);
    int off;
    if (inst[6:2] != 5'b11000 || !inst[31]) return pc + 32'd4;
    off = -4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
    return pc + off;
  endfunction

  // ---------------- memory responder ----------------
  int          cfg_ar = 0, cfg_r = 0, cur_ar = 0, cur_r = 0, ar_wait = 0, r_wait = 0;
  bit          rand_lat = 0;
  logic        r_pend = 1'b0;
  logic [31:0] r_data = '0;
  logic [1:0]  resp_val = 2'b00;
  logic [31:0] ar_log [$];

  assign mem_arready = mem_arvalid && (ar_wait >= (rand_lat ? cur_ar : cfg_ar));
  assign mem_rvalid  = r_pend && (r_wait >= (rand_lat ? cur_r : cfg_r));
  assign mem_rdata   = mem_rvalid ? r_data : 32'hdead_beef;
  assign mem_rresp   = resp_val;

  always @(posedge clock) begin
    if (reset) begin
      ar_wait <= 0;
      r_wait  <= 0;
      r_pend  <= 1'b0;
    end else begin
      if (mem_arvalid && !mem_arready) ar_wait <= ar_wait + 1;
      if (mem_arvalid && mem_arready) begin
        ar_wait <= 0;
        r_wait  <= 0;
        r_pend  <= 1'b1;
        r_data  <= mem_word(mem_araddr);
        ar_log.push_back(mem_araddr);
        cur_ar  <= $urandom_range(0, 2);
        cur_r   <= $urandom_range(0, 3);
      end else if (r_pend && !mem_rvalid) begin
        r_wait <= r_wait + 1;
      end
      if (mem_rvalid && mem_rready) r_pend <= 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- wait helpers (bounded) ----------------
  task automatic wait_valid();
    for (int k = 0; k < 60; k++) begin
      if (out_valid) return;
      @(negedge clock);
    end
    errors++;
    $display("FAIL wait_valid: out_valid=0 after 60 cycles, required 1");
  endtask

  task automatic wait_ar(input int n);
    for (int k = 0; k < 60; k++) begin
      if (ar_log.size() > n) return;
      @(negedge clock);
    end
    errors++;
    $display("FAIL wait_ar: %0d address handshakes, required more than %0d", ar_log.size(), n);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    wait_valid();
    flush      = 1'b1;
    flush_dnpc = a;
    @(negedge clock);
    flush      = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n;
    bit seen;
    mem_ovr[32'h3000_0000] = 32'h0000_0013;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || mem_arvalid !== 1'b0 || mem_rready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b arvalid=%b rready=%b, required 0 0 0",
               out_valid, mem_arvalid, mem_rready);
    end
    reset = 1'b0;
    seen  = 0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clock);
      if (mem_arvalid) seen = 1;
    end
    checks++;
    if (!seen || mem_araddr !== 32'h3000_0000) begin
      errors++;
      $display("FAIL reset_araddr: arvalid=%b araddr=%h, required 1 30000000", seen, mem_araddr);
    end
    wait_valid();
    checks++;
    if (out_pc !== 32'h3000_0000 || out_inst !== 32'h0000_0013) begin
      errors++;
      $display("FAIL reset_first: pc=%h inst=%h, required 30000000 00000013", out_pc, out_inst);
    end
    n = ar_log.size();
    accept();
    wait_ar(n);
    checks++;
    if (ar_log.size() <= n || ar_log[n] !== 32'h3000_0004) begin
      errors++;
      $display("FAIL reset_next: araddr=%h, required 30000004",
               ar_log.size() > n ? ar_log[n] : 32'hx);
    end
  endtask

  task automatic test_branch();
    int          imms [2] = '{-8, 12};
    logic [31:0] exps [2] = '{32'h3000_0008, 32'h3000_0014};
    int n;
    for (int c = 0; c < 2; c++) begin
      mem_ovr[32'h3000_0010] = enc_b(imms[c]);
      goto_pc(32'h3000_0010);
      wait_valid();
      checks++;
      if (out_pc !== 32'h3000_0010 || out_inst !== enc_b(imms[c])) begin
        errors++;
        $display("FAIL branch_buf%0d: pc=%h inst=%h, required 30000010 %h",
                 c, out_pc, out_inst, enc_b(imms[c]));
      end
      n = ar_log.size();
      accept();
      wait_ar(n);
      checks++;
      if (ar_log.size() <= n || ar_log[n] !== exps[c]) begin
        errors++;
        $display("FAIL branch_npc%0d: araddr=%h, required %h",
                 c, ar_log.size() > n ? ar_log[n] : 32'hx, exps[c]);
      end
    end
  endtask

  task automatic test_jump_wait();
    int n, bad;
    cfg_r = 3;
    wait_valid();
    n = ar_log.size();
    accept();
    wait_ar(n);
    jump_flush = 1'b1;
    jump_dnpc  = 32'h3000_0100;
    @(negedge clock);
    jump_flush = 1'b0;
    bad = 0;
    for (int k = 0; k < 30 && ar_log.size() <= n + 1; k++) begin
      if (out_valid) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0 || ar_log.size() <= n + 1 || ar_log[n+1] !== 32'h3000_0100) begin
      errors++;
      $display("FAIL jump_wait: stale valid cycles=%0d refetch=%h, required 0 30000100",
               bad, ar_log.size() > n + 1 ? ar_log[n+1] : 32'hx);
    end
    wait_valid();
    checks++;
    if (out_pc !== 32'h3000_0100) begin
      errors++;
      $display("FAIL jump_wait_pc: pc=%h, required 30000100", out_pc);
    end
    cfg_r = 0;
  endtask

  task automatic test_jump_req();
    int n, bad;
    logic [31:0] a;
    cfg_ar = 2;
    wait_valid();
    n = ar_log.size();
    accept();
    a = mem_araddr;
    checks++;
    if (mem_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL jump_req_arvalid: arvalid=%b, required 1", mem_arvalid);
    end
    jump_flush = 1'b1;
    jump_dnpc  = 32'h3000_0400;
    @(negedge clock);
    jump_flush = 1'b0;
    bad = 0;
    for (int k = 0; k < 10 && ar_log.size() <= n; k++) begin
      if (mem_arvalid && mem_araddr !== a) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0 || ar_log.size() <= n || ar_log[n] !== a) begin
      errors++;
      $display("FAIL jump_req_stable: unstable cycles=%0d issued=%h, required 0 %h",
               bad, ar_log.size() > n ? ar_log[n] : 32'hx, a);
    end
    wait_ar(n + 1);
    checks++;
    if (ar_log.size() <= n + 1 || ar_log[n+1] !== 32'h3000_0400) begin
      errors++;
      $display("FAIL jump_req_refetch: araddr=%h, required 30000400",
               ar_log.size() > n + 1 ? ar_log[n+1] : 32'hx);
    end
    wait_valid();
    checks++;
    if (out_pc !== 32'h3000_0400) begin
      errors++;
      $display("FAIL jump_req_pc: pc=%h, required 30000400", out_pc);
    end
    cfg_ar = 0;
  endtask

  task automatic test_flush_both();
    int n;
    wait_valid();
    n          = ar_log.size();
    flush      = 1'b1;
    flush_dnpc = 32'h3000_0200;
    jump_flush = 1'b1;
    jump_dnpc  = 32'h3000_0300;
    out_ready  = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_gate: out_valid=%b, required 0", out_valid);
    end
    @(negedge clock);
    flush      = 1'b0;
    jump_flush = 1'b0;
    out_ready  = 1'b0;
    wait_ar(n);
    checks++;
    if (ar_log.size() <= n || ar_log[n] !== 32'h3000_0200) begin
      errors++;
      $display("FAIL flush_prio: araddr=%h, required 30000200",
               ar_log.size() > n ? ar_log[n] : 32'hx);
    end
    wait_valid();
    checks++;
    if (out_pc !== 32'h3000_0200) begin
      errors++;
      $display("FAIL flush_pc: pc=%h, required 30000200", out_pc);
    end
  endtask

  task automatic test_stall();
    int n;
    logic [31:0] p, i;
    wait_valid();
    p = out_pc;
    i = out_inst;
    n = ar_log.size();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== p || out_inst !== i ||
          mem_arvalid !== 1'b0 || ar_log.size() != n) begin
        errors++;
        $display("FAIL stall%0d: valid=%b pc=%h inst=%h arvalid=%b, required 1 %h %h 0",
                 k, out_valid, out_pc, out_inst, mem_arvalid, p, i);
      end
    end
    accept();
  endtask

`ifdef YSYX_23060203_IFU_RESP_CHECK_EN
  task automatic test_fetch_err();
    resp_val = 2'b10;
    goto_pc(32'h3000_0800);
    wait_valid();
    checks++;
    if (out_fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL fetch_err: out_fetch_err=%b, required 1", out_fetch_err);
    end
    resp_val = 2'b00;
    goto_pc(32'h3000_0900);
    wait_valid();
    checks++;
    if (out_fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL fetch_err_clear: out_fetch_err=%b, required 0", out_fetch_err);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] exp_pc, tgt, w;
    int delivered, sel;
    rand_lat = 1;
    goto_pc(32'h3000_1000);
    exp_pc    = 32'h3000_1000;
    delivered = 0;
    for (int cyc = 0; cyc < 20000 && delivered < 200; cyc++) begin
      if ($urandom_range(0, 15) == 0) begin
        tgt = $urandom & 32'hffff_fffc;
        sel = $urandom_range(0, 2);
        jump_flush = (sel != 1);
        jump_dnpc  = tgt ^ 32'h0000_0040;
        flush      = (sel != 0);
        flush_dnpc = tgt;
        exp_pc     = (sel != 0) ? tgt : (tgt ^ 32'h0000_0040);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_redir_gate: out_valid=%b, required 0", out_valid);
        end
        @(negedge clock);
        jump_flush = 1'b0;
        flush      = 1'b0;
      end else if (out_valid && $urandom_range(0, 1) == 1) begin
        w = mem_word(exp_pc);
        checks++;
        if (out_pc !== exp_pc || out_inst !== w) begin
          errors++;
          $display("FAIL rand_stream%0d: pc=%h inst=%h, required %h %h",
                   delivered, out_pc, out_inst, exp_pc, w);
        end
        exp_pc = ref_next(exp_pc, w);
        delivered++;
        accept();
      end else begin
        @(negedge clock);
      end
    end
    checks++;
    if (delivered < 200) begin
      errors++;
      $display("FAIL rand_progress: delivered=%0d, required 200", delivered);
    end
    rand_lat = 0;
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_branch();
    test_jump_wait();
    test_jump_req();
    test_flush_both();
    test_stall();
`ifdef YSYX_23060203_IFU_RESP_CHECK_EN
    test_fetch_err();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
